// File: rtl/trng_conditioner_zeptobars_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trng_conditioner_zeptobars_pkg
// Description : Shared types and parameter defaults for the TRNG conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package trng_conditioner_zeptobars_pkg;

    // Parameter defaults shared by the conditioner and its bench
    localparam int c_sample_div_default = 4;
    localparam int c_rct_limit_default  = 32;
    localparam int c_fifo_depth_default = 4;

    // Von Neumann debias pair tracker
    typedef enum logic [0:0] {
        ST_EMPTY      = 1'b0,
        ST_HAVE_FIRST = 1'b1
    } debias_state_t;

endpackage
`default_nettype wire

// File: rtl/trng_fifo_zeptobars.sv
`default_nettype none
// ============================================================================
// Module      : trng_fifo_zeptobars
// Description : Small synchronous FIFO for conditioned bytes. A push into a
//               full FIFO is dropped unless a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_fifo_zeptobars #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic             drop
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
    localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
    localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_full    = (r_count == c_depth);
    assign valid     = (r_count != '0);
    assign w_pop     = valid && pop;
    // When full, a simultaneous pop frees the slot the push needs
    assign w_push_ok = push && (!w_full || w_pop);
    assign drop      = push && w_full && !w_pop;
    assign pop_data  = valid ? r_mem[r_rd_ptr] : '0;

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trng_conditioner_zeptobars.sv
`default_nettype none
// ============================================================================
// Module      : trng_conditioner_zeptobars
// Description : Samples a raw oscillator bit, runs a repetition-count health
//               test, optionally von Neumann debiases, packs bits into bytes
//               and queues them in a small output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_conditioner_zeptobars
    import trng_conditioner_zeptobars_pkg::*;
#(
    parameter int SAMPLE_DIV = c_sample_div_default,
    parameter int RCT_LIMIT  = c_rct_limit_default,
    parameter int FIFO_DEPTH = c_fifo_depth_default
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_bit,
    input  logic       en,
    input  logic       debias_en,
    input  logic       clr,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       health_fail,
    output logic       overflow
);

    localparam logic [7:0] c_div_max   = 8'(SAMPLE_DIV - 1);
    localparam logic [7:0] c_rct_limit = 8'(RCT_LIMIT);

    logic          r_sync_meta;
    logic          r_sync_bit;
    logic [7:0]    r_div_cnt;
    logic          w_sample;
    logic          r_prev;
    logic [7:0]    r_run_cnt;
    logic [7:0]    w_run_next;
    logic          r_health_fail;
    debias_state_t r_state;
    debias_state_t w_state_next;
    logic          r_first_bit;
    logic          w_emit;
    logic          w_emit_bit;
    logic          w_pack;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    w_byte;
    logic          w_push;
    logic          w_drop;
    logic          r_overflow;

    // Two-flop synchronizer for the asynchronous entropy source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_sync_bit  <= 1'b0;
        end else begin
            r_sync_meta <= raw_bit;
            r_sync_bit  <= r_sync_meta;
        end
    end

    // A clear in the same cycle suppresses the sample
    assign w_sample = en && !clr && (r_div_cnt == c_div_max);

    // Sample divider: free-runs while enabled, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (clr) begin
            r_div_cnt <= '0;
        end else if (en) begin
            r_div_cnt <= (r_div_cnt == c_div_max) ? 8'd0 : r_div_cnt + 8'd1;
        end
    end

    // Next run length: restart on change, otherwise saturating increment
    always_comb begin
        w_run_next = r_run_cnt;
        if (r_sync_bit != r_prev) begin
            w_run_next = 8'd1;
        end else if (r_run_cnt != c_rct_limit) begin
            w_run_next = r_run_cnt + 8'd1;
        end
    end

    // Repetition-count health test with sticky failure flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev        <= 1'b0;
            r_run_cnt     <= '0;
            r_health_fail <= 1'b0;
        end else if (clr) begin
            r_run_cnt     <= '0;
            r_health_fail <= 1'b0;
        end else if (w_sample) begin
            r_prev    <= r_sync_bit;
            r_run_cnt <= w_run_next;
            if (w_run_next == c_rct_limit) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    // Debias FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else if (clr) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Debias next-state and emit; pass-through pins the FSM in EMPTY
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_emit_bit   = r_sync_bit;
        if (!debias_en) begin
            w_state_next = ST_EMPTY;
            w_emit       = w_sample;
        end else if (w_sample) begin
            case (r_state)
                ST_EMPTY: begin
                    w_state_next = ST_HAVE_FIRST;
                end
                ST_HAVE_FIRST: begin
                    w_state_next = ST_EMPTY;
                    w_emit       = (r_first_bit != r_sync_bit);
                    w_emit_bit   = r_first_bit;
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Capture the first bit of a debias pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_bit <= 1'b0;
        end else if (w_sample && debias_en && (r_state == ST_EMPTY)) begin
            r_first_bit <= r_sync_bit;
        end
    end

    // A failed health test blocks bits from reaching the packer
    assign w_pack = w_emit && !r_health_fail;
    assign w_byte = {r_shift[6:0], w_emit_bit};
    assign w_push = w_pack && (r_bit_cnt == 3'd7);

    // Byte packer, MSB-first; the bit counter wraps to 0 on the 8th bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (clr) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_pack) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    trng_fifo_zeptobars #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_byte),
        .pop       (out_ready),
        .pop_data  (out_data),
        .valid     (out_valid),
        .drop      (w_drop)
    );

    // Sticky overflow flag for dropped bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign health_fail = r_health_fail;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: doc/trng_conditioner_zeptobars.md
TRNG_CONDITIONER_ZEPTOBARS -- requirements
Module: trng_conditioner_zeptobars

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 4: clk cycles between raw-bit samples (range 1..255).
REQ-002 SHALL have parameter RCT_LIMIT, default 32: count of identical consecutive samples that trips the health test (range 2..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output byte FIFO depth (power of two, range 2..16).
REQ-004 clk  input  1  single system clock; all state on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 raw_bit  input  1  raw entropy bit from the oscillator mux; asynchronous to clk.
REQ-007 en  input  1  sampling enable.
REQ-008 debias_en  input  1  1 = von Neumann debiasing, 0 = pass-through.
REQ-009 clr  input  1  synchronous clear of flags and packing state.
REQ-010 out_data  output  8  FIFO head byte.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 health_fail  output  1  sticky repetition-count failure.
REQ-014 overflow  output  1  sticky flag: a completed byte was dropped.

Function
REQ-015 raw_bit SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Sample counter SHALL count 0..SAMPLE_DIV-1 while en=1, strobe one sample on reaching SAMPLE_DIV-1, then wrap to 0; with en=0 it SHALL hold, producing no samples.
REQ-017 Health test: on each sample, equal to previous sample -> run counter +1 (saturating at RCT_LIMIT); different -> run counter =1; run counter reaching RCT_LIMIT SHALL set health_fail the next cycle.
REQ-018 With health_fail=1, no bits SHALL enter the packer; FIFO SHALL continue draining.
REQ-019 Debias FSM states: EMPTY, HAVE_FIRST. EMPTY + sample -> store bit, HAVE_FIRST. HAVE_FIRST + sample -> emit stored bit if samples differ, else emit nothing; -> EMPTY.
REQ-020 With debias_en=0 every sample SHALL be emitted directly; FSM held in EMPTY.
REQ-021 Packer SHALL shift each emitted bit in at bit 0 (earlier bits move toward bit 7); 3-bit bit counter; 8th bit SHALL produce a complete byte pushed to the FIFO in the same cycle, counter -> 0.
REQ-022 Push on full FIFO without simultaneous pop SHALL drop the byte and set overflow; push and pop in the same cycle when full SHALL both succeed.
REQ-023 Pop SHALL occur when out_valid && out_ready; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Push to empty FIFO SHALL raise out_valid the following cycle (first-word latency 1 cycle after push).
REQ-025 clr=1 SHALL clear health_fail, overflow, run counter, debias FSM, packer and sample counter next cycle, leaving FIFO contents untouched; clr has priority over sampling in that cycle.
REQ-026 Changing debias_en mid-pair SHALL take effect on the next sample; a stored HAVE_FIRST bit is discarded.

Reset
REQ-027 rst=1 SHALL asynchronously clear: synchronizer, sample counter, run counter, previous-sample register, FSM -> EMPTY, packer, FIFO pointers; out_valid=0, out_data=0, health_fail=0, overflow=0.
REQ-028 Reset mid-byte or mid-pair SHALL discard partial data; no byte is emitted by reset.

Structure
REQ-029 Shared package SHALL hold the debias FSM state enum and default values for SAMPLE_DIV, RCT_LIMIT, FIFO_DEPTH.
REQ-030 FIFO SHALL be a separate sub-module, trng_fifo_zeptobars (parameterised depth, width 8, same clk/rst).

Verification
REQ-031 debias_en=0, SAMPLE_DIV=1, raw_bit pattern 1,0,1,1,0,0,1,0 (held per cycle, sync latency accounted) -> out_data=8'hB2, out_valid=1.
REQ-032 debias_en=1, sample pairs 10,01,11,00,10,10,01,01,10,01 -> emitted bits 1,0,1,1,0,0,1,0 -> out_data=8'hB2; equal pairs produce nothing.
REQ-033 raw_bit held 1, RCT_LIMIT=32, SAMPLE_DIV=4 -> health_fail=1 after 32nd sample; no further bytes; clr=1 -> health_fail=0.
REQ-034 out_ready=0, FIFO_DEPTH=4, five bytes generated -> four queued, overflow=1; then out_ready=1 -> four bytes drain in order.
REQ-035 rst asserted mid-byte (5 bits packed), then released -> out_valid=0, next byte built from fresh 8 bits only.
REQ-036 FIFO full with out_ready=1 held during push -> no overflow, byte order preserved.
